// File: rtl/data_bus_pkg.sv
// Shared constants and types for the CPU data-bus hub: default sizes,
// source-index assignments and the bus word type.
package data_bus_pkg;

   localparam int DATA_BUS_WIDTH = 16;
   localparam int DATA_BUS_N_SRC = 8;

   localparam int SRC_DST      = 0;
   localparam int SRC_SRC      = 1;
   localparam int SRC_RAM      = 2;
   localparam int SRC_PC       = 3;
   localparam int SRC_OPERAND  = 4;
   localparam int SRC_KEYBOARD = 5;
   localparam int SRC_SP       = 6;
   localparam int SRC_SPARE    = 7;

   typedef logic [DATA_BUS_WIDTH-1:0] bus_word_t;

endpackage

// File: rtl/data_bus_hub_n_if.sv
// Signal bundle between the control unit / sources and the data-bus hub.
// The master drives sources and controls; the slave is the hub itself.
interface data_bus_hub_n_if
   import data_bus_pkg::*;
#(
   parameter int WIDTH     = DATA_BUS_WIDTH,
   parameter int N_SRC     = DATA_BUS_N_SRC,
   parameter int CNT_WIDTH = 8
);
   localparam int SRC_IDX_W = $clog2(N_SRC);

   logic [N_SRC*WIDTH-1:0] SRC_DATA;
   logic [N_SRC-1:0]       SRC_EN;
   logic [WIDTH-1:0]       ALWAYS_ON;
   logic                   HOLD;
   logic                   CLEAR_ERR;
   logic [WIDTH-1:0]       DATA_BUS;
   logic [WIDTH-1:0]       DATA_BUS_Q;
   logic                   BUS_VALID;
   logic [SRC_IDX_W-1:0]   LAST_SRC;
   logic                   CONTENTION;
   logic                   CONTENTION_STICKY;
   logic [CNT_WIDTH-1:0]   CONTENTION_COUNT;

   modport master (
      output SRC_DATA, SRC_EN, ALWAYS_ON, HOLD, CLEAR_ERR,
      input  DATA_BUS, DATA_BUS_Q, BUS_VALID, LAST_SRC,
             CONTENTION, CONTENTION_STICKY, CONTENTION_COUNT
   );

   modport slave (
      input  SRC_DATA, SRC_EN, ALWAYS_ON, HOLD, CLEAR_ERR,
      output DATA_BUS, DATA_BUS_Q, BUS_VALID, LAST_SRC,
             CONTENTION, CONTENTION_STICKY, CONTENTION_COUNT
   );

endinterface

// File: rtl/bus_enable_decoder.sv
// Classifies the bus-enable vector: any / exactly-one / several set,
// plus the encoded index of the lowest set enable.
module bus_enable_decoder #(
   parameter int  N_SRC     = 8,
   localparam int SRC_IDX_W = $clog2(N_SRC)
) (
   input  logic [N_SRC-1:0]     src_en,
   output logic                 any_en,
   output logic                 one_hot,
   output logic                 multi_en,
   output logic [SRC_IDX_W-1:0] low_idx
);

   logic [N_SRC-1:0] rest_bits;

   // Clearing the lowest set bit leaves zero only when at most one bit was set.
   assign rest_bits = src_en & (src_en - N_SRC'(1));
   assign any_en    = |src_en;
   assign one_hot   = any_en & ~(|rest_bits);
   assign multi_en  = |rest_bits;

   always_comb begin
      low_idx = '0;
      for (int i = N_SRC - 1; i >= 0; i--) begin
         if (src_en[i]) low_idx = SRC_IDX_W'(i);
      end
   end

endmodule

// File: rtl/data_bus_hub_n.sv
// Data-bus hub: OR-merge of gated sources, registered keeper copy with
// last-driver tracking; contention logic only with DATA_BUS_CONTENTION_CHECK_EN.
module data_bus_hub_n
   import data_bus_pkg::*;
#(
   parameter int WIDTH     = DATA_BUS_WIDTH,
   parameter int N_SRC     = DATA_BUS_N_SRC,
   parameter int CNT_WIDTH = 8
) (
   input  logic            CLK,
   input  logic            RESET,
   data_bus_hub_n_if.slave bus
);

   localparam int SRC_IDX_W = $clog2(N_SRC);

   logic [WIDTH-1:0]     gated [N_SRC];
   logic [WIDTH-1:0]     merged;
   logic                 any_en;
   logic                 one_hot;
   logic                 multi_en;
   logic [SRC_IDX_W-1:0] low_idx;

   logic [WIDTH-1:0]     data_q_reg;
   logic                 valid_reg;
   logic [SRC_IDX_W-1:0] last_src_reg;

   bus_enable_decoder #(.N_SRC(N_SRC)) u_dec (
      .src_en   (bus.SRC_EN),
      .any_en   (any_en),
      .one_hot  (one_hot),
      .multi_en (multi_en),
      .low_idx  (low_idx)
   );

   for (genvar gi = 0; gi < N_SRC; gi++) begin : g_gate
      assign gated[gi] = bus.SRC_DATA[gi*WIDTH +: WIDTH] & {WIDTH{bus.SRC_EN[gi]}};
   end

   always_comb begin
      merged = bus.ALWAYS_ON;
      for (int i = 0; i < N_SRC; i++) merged = merged | gated[i];
   end

   assign bus.DATA_BUS = merged;

   // The unconditional term alone never loads the keeper.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         data_q_reg   <= '0;
         valid_reg    <= 1'b0;
         last_src_reg <= '0;
      end else if (!bus.HOLD) begin
         valid_reg <= any_en;
         if (any_en)  data_q_reg   <= merged;
         if (one_hot) last_src_reg <= low_idx;
      end
   end

   assign bus.DATA_BUS_Q = data_q_reg;
   assign bus.BUS_VALID  = valid_reg;
   assign bus.LAST_SRC   = last_src_reg;

`ifdef DATA_BUS_CONTENTION_CHECK_EN
   logic                 sticky_reg;
   logic [CNT_WIDTH-1:0] count_reg;

   // A contention in the same cycle as a clear restarts the count at one.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         sticky_reg <= 1'b0;
         count_reg  <= '0;
      end else if (multi_en && !bus.HOLD) begin
         sticky_reg <= 1'b1;
         if (bus.CLEAR_ERR)       count_reg <= CNT_WIDTH'(1);
         else if (count_reg != '1) count_reg <= count_reg + CNT_WIDTH'(1);
      end else if (bus.CLEAR_ERR) begin
         sticky_reg <= 1'b0;
         count_reg  <= '0;
      end
   end

   assign bus.CONTENTION        = multi_en;
   assign bus.CONTENTION_STICKY = sticky_reg;
   assign bus.CONTENTION_COUNT  = count_reg;
`else
   logic unused_contention;
   assign unused_contention     = &{1'b0, multi_en, bus.CLEAR_ERR};
   assign bus.CONTENTION        = 1'b0;
   assign bus.CONTENTION_STICKY = 1'b0;
   assign bus.CONTENTION_COUNT  = '0;
`endif

endmodule

// File: tb/tb_data_bus_hub_n.sv
// Directed bench for data_bus_hub_n; contention expectations follow
// whether DATA_BUS_CONTENTION_CHECK_EN is defined.
module tb_data_bus_hub_n;

   localparam int W  = 16;
   localparam int NS = 8;
   localparam int CW = 8;
`ifdef DATA_BUS_CONTENTION_CHECK_EN
   localparam bit CEN = 1'b1;
`else
   localparam bit CEN = 1'b0;
`endif

   logic CLK = 1'b0;
   logic RESET;
   int   checks = 0;
   int   failures = 0;

   data_bus_hub_n_if #(.WIDTH(W), .N_SRC(NS), .CNT_WIDTH(CW)) bus_if ();

   data_bus_hub_n #(.WIDTH(W), .N_SRC(NS), .CNT_WIDTH(CW)) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (bus_if)
   );

   always #5 CLK = ~CLK;

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic set_src(input int idx, input logic [W-1:0] val);
      bus_if.SRC_DATA[idx*W +: W] = val;
   endtask

   task automatic test_reset();
      RESET = 1'b1;
      bus_if.ALWAYS_ON = 16'h0005;
      step();
      checks++; if (bus_if.DATA_BUS_Q !== 16'h0) begin failures++; $display("FAIL reset_q actual=%h required=0000", bus_if.DATA_BUS_Q); end
      checks++; if (bus_if.BUS_VALID !== 1'b0) begin failures++; $display("FAIL reset_valid actual=%b required=0", bus_if.BUS_VALID); end
      checks++; if (bus_if.LAST_SRC !== 3'd0) begin failures++; $display("FAIL reset_last actual=%0d required=0", bus_if.LAST_SRC); end
      checks++; if (bus_if.CONTENTION_STICKY !== 1'b0 || bus_if.CONTENTION_COUNT !== 8'd0) begin failures++; $display("FAIL reset_cont actual=%b/%0d required=0/0", bus_if.CONTENTION_STICKY, bus_if.CONTENTION_COUNT); end
      checks++; if (bus_if.DATA_BUS !== 16'h0005) begin failures++; $display("FAIL reset_comb_bus actual=%h required=0005", bus_if.DATA_BUS); end
      $display("txn reset: q=%h valid=%b last=%0d bus=%h", bus_if.DATA_BUS_Q, bus_if.BUS_VALID, bus_if.LAST_SRC, bus_if.DATA_BUS);
      RESET = 1'b0;
      bus_if.ALWAYS_ON = '0;
   endtask

   task automatic test_single_source();
      set_src(2, 16'h1234);
      bus_if.SRC_EN = 8'b0000_0100;
      #1;
      checks++; if (bus_if.DATA_BUS !== 16'h1234) begin failures++; $display("FAIL single_comb actual=%h required=1234", bus_if.DATA_BUS); end
      checks++; if (bus_if.CONTENTION !== 1'b0) begin failures++; $display("FAIL single_cont actual=%b required=0", bus_if.CONTENTION); end
      step();
      checks++; if (bus_if.DATA_BUS_Q !== 16'h1234 || bus_if.BUS_VALID !== 1'b1 || bus_if.LAST_SRC !== 3'd2) begin failures++; $display("FAIL single_reg actual=%h/%b/%0d required=1234/1/2", bus_if.DATA_BUS_Q, bus_if.BUS_VALID, bus_if.LAST_SRC); end
      $display("txn single: q=%h valid=%b last=%0d", bus_if.DATA_BUS_Q, bus_if.BUS_VALID, bus_if.LAST_SRC);
   endtask

   task automatic test_keeper();
      bus_if.SRC_EN = '0;
      bus_if.ALWAYS_ON = 16'h00F0;
      #1;
      checks++; if (bus_if.DATA_BUS !== 16'h00F0) begin failures++; $display("FAIL keeper_comb actual=%h required=00f0", bus_if.DATA_BUS); end
      step();
      checks++; if (bus_if.DATA_BUS_Q !== 16'h1234 || bus_if.BUS_VALID !== 1'b0 || bus_if.LAST_SRC !== 3'd2) begin failures++; $display("FAIL keeper_reg actual=%h/%b/%0d required=1234/0/2", bus_if.DATA_BUS_Q, bus_if.BUS_VALID, bus_if.LAST_SRC); end
      $display("txn keeper: bus=%h q=%h valid=%b", bus_if.DATA_BUS, bus_if.DATA_BUS_Q, bus_if.BUS_VALID);
      bus_if.ALWAYS_ON = '0;
   endtask

   task automatic test_back_to_back();
      set_src(3, 16'h0F00);
      set_src(6, 16'h00FF);
      bus_if.SRC_EN = 8'b0000_1000;
      step();
      checks++; if (bus_if.DATA_BUS_Q !== 16'h0F00 || bus_if.BUS_VALID !== 1'b1 || bus_if.LAST_SRC !== 3'd3) begin failures++; $display("FAIL b2b_first actual=%h/%b/%0d required=0f00/1/3", bus_if.DATA_BUS_Q, bus_if.BUS_VALID, bus_if.LAST_SRC); end
      bus_if.SRC_EN = 8'b0100_0000;
      step();
      checks++; if (bus_if.DATA_BUS_Q !== 16'h00FF || bus_if.BUS_VALID !== 1'b1 || bus_if.LAST_SRC !== 3'd6) begin failures++; $display("FAIL b2b_second actual=%h/%b/%0d required=00ff/1/6", bus_if.DATA_BUS_Q, bus_if.BUS_VALID, bus_if.LAST_SRC); end
      $display("txn back_to_back: q=%h valid=%b last=%0d", bus_if.DATA_BUS_Q, bus_if.BUS_VALID, bus_if.LAST_SRC);
   endtask

   task automatic test_contention();
      bus_if.SRC_EN = 8'b0100_1000;
      #1;
      checks++; if (bus_if.DATA_BUS !== 16'h0FFF) begin failures++; $display("FAIL cont_comb_bus actual=%h required=0fff", bus_if.DATA_BUS); end
      checks++; if (bus_if.CONTENTION !== CEN) begin failures++; $display("FAIL cont_comb actual=%b required=%b", bus_if.CONTENTION, CEN); end
      step();
      checks++; if (bus_if.CONTENTION_STICKY !== CEN || bus_if.CONTENTION_COUNT !== (CEN ? 8'd1 : 8'd0)) begin failures++; $display("FAIL cont_first actual=%b/%0d required=%b/%0d", bus_if.CONTENTION_STICKY, bus_if.CONTENTION_COUNT, CEN, CEN ? 1 : 0); end
      checks++; if (bus_if.LAST_SRC !== 3'd6 || bus_if.DATA_BUS_Q !== 16'h0FFF || bus_if.BUS_VALID !== 1'b1) begin failures++; $display("FAIL cont_reg actual=%0d/%h/%b required=6/0fff/1", bus_if.LAST_SRC, bus_if.DATA_BUS_Q, bus_if.BUS_VALID); end
      $display("txn contention: sticky=%b count=%0d last=%0d", bus_if.CONTENTION_STICKY, bus_if.CONTENTION_COUNT, bus_if.LAST_SRC);
      for (int i = 1; i < 254; i++) step();
      checks++; if (bus_if.CONTENTION_COUNT !== (CEN ? 8'd254 : 8'd0)) begin failures++; $display("FAIL cont_254 actual=%0d required=%0d", bus_if.CONTENTION_COUNT, CEN ? 254 : 0); end
      for (int i = 254; i < 300; i++) step();
      checks++; if (bus_if.CONTENTION_COUNT !== (CEN ? 8'd255 : 8'd0) || bus_if.CONTENTION_STICKY !== CEN) begin failures++; $display("FAIL cont_saturate actual=%0d/%b required=%0d/%b", bus_if.CONTENTION_COUNT, bus_if.CONTENTION_STICKY, CEN ? 255 : 0, CEN); end
      $display("txn saturate: count=%0d sticky=%b", bus_if.CONTENTION_COUNT, bus_if.CONTENTION_STICKY);
   endtask

   task automatic test_clear_race();
      bus_if.CLEAR_ERR = 1'b1;
      step();
      checks++; if (bus_if.CONTENTION_STICKY !== CEN || bus_if.CONTENTION_COUNT !== (CEN ? 8'd1 : 8'd0)) begin failures++; $display("FAIL clear_race actual=%b/%0d required=%b/%0d", bus_if.CONTENTION_STICKY, bus_if.CONTENTION_COUNT, CEN, CEN ? 1 : 0); end
      bus_if.SRC_EN = '0;
      step();
      checks++; if (bus_if.CONTENTION_STICKY !== 1'b0 || bus_if.CONTENTION_COUNT !== 8'd0) begin failures++; $display("FAIL clear_alone actual=%b/%0d required=0/0", bus_if.CONTENTION_STICKY, bus_if.CONTENTION_COUNT); end
      $display("txn clear: sticky=%b count=%0d", bus_if.CONTENTION_STICKY, bus_if.CONTENTION_COUNT);
      bus_if.CLEAR_ERR = 1'b0;
   endtask

   task automatic test_hold();
      bus_if.SRC_EN = 8'b0000_0100;
      step();
      set_src(4, 16'hBEEF);
      set_src(5, 16'h0001);
      bus_if.HOLD = 1'b1;
      bus_if.SRC_EN = 8'b0001_0000;
      #1;
      checks++; if (bus_if.DATA_BUS !== 16'hBEEF) begin failures++; $display("FAIL hold_comb actual=%h required=beef", bus_if.DATA_BUS); end
      step();
      checks++; if (bus_if.DATA_BUS_Q !== 16'h1234 || bus_if.BUS_VALID !== 1'b1 || bus_if.LAST_SRC !== 3'd2) begin failures++; $display("FAIL hold_reg actual=%h/%b/%0d required=1234/1/2", bus_if.DATA_BUS_Q, bus_if.BUS_VALID, bus_if.LAST_SRC); end
      bus_if.SRC_EN = 8'b0011_0000;
      #1;
      checks++; if (bus_if.CONTENTION !== CEN) begin failures++; $display("FAIL hold_cont_comb actual=%b required=%b", bus_if.CONTENTION, CEN); end
      step();
      checks++; if (bus_if.CONTENTION_STICKY !== 1'b0 || bus_if.CONTENTION_COUNT !== 8'd0 || bus_if.DATA_BUS_Q !== 16'h1234) begin failures++; $display("FAIL hold_cont_reg actual=%b/%0d/%h required=0/0/1234", bus_if.CONTENTION_STICKY, bus_if.CONTENTION_COUNT, bus_if.DATA_BUS_Q); end
      bus_if.HOLD = 1'b0;
      bus_if.SRC_EN = 8'b0001_0000;
      step();
      checks++; if (bus_if.DATA_BUS_Q !== 16'hBEEF || bus_if.LAST_SRC !== 3'd4) begin failures++; $display("FAIL hold_release actual=%h/%0d required=beef/4", bus_if.DATA_BUS_Q, bus_if.LAST_SRC); end
      $display("txn hold: q=%h valid=%b last=%0d", bus_if.DATA_BUS_Q, bus_if.BUS_VALID, bus_if.LAST_SRC);
   endtask

   task automatic test_async_reset();
      bus_if.SRC_EN = 8'b0100_1000;
      step();
      checks++; if (bus_if.CONTENTION_STICKY !== CEN) begin failures++; $display("FAIL async_pre actual=%b required=%b", bus_if.CONTENTION_STICKY, CEN); end
      #2;
      RESET = 1'b1;
      #1;
      checks++; if (bus_if.DATA_BUS_Q !== 16'h0 || bus_if.BUS_VALID !== 1'b0 || bus_if.LAST_SRC !== 3'd0 || bus_if.CONTENTION_STICKY !== 1'b0 || bus_if.CONTENTION_COUNT !== 8'd0) begin failures++; $display("FAIL async_clear actual=%h/%b/%0d/%b/%0d required=0000/0/0/0/0", bus_if.DATA_BUS_Q, bus_if.BUS_VALID, bus_if.LAST_SRC, bus_if.CONTENTION_STICKY, bus_if.CONTENTION_COUNT); end
      checks++; if (bus_if.DATA_BUS !== 16'h0FFF || bus_if.CONTENTION !== CEN) begin failures++; $display("FAIL async_comb actual=%h/%b required=0fff/%b", bus_if.DATA_BUS, bus_if.CONTENTION, CEN); end
      #1;
      RESET = 1'b0;
      set_src(1, 16'hA5A5);
      bus_if.SRC_EN = 8'b0000_0010;
      step();
      checks++; if (bus_if.DATA_BUS_Q !== 16'hA5A5 || bus_if.BUS_VALID !== 1'b1 || bus_if.LAST_SRC !== 3'd1 || bus_if.CONTENTION_STICKY !== 1'b0) begin failures++; $display("FAIL async_reload actual=%h/%b/%0d/%b required=a5a5/1/1/0", bus_if.DATA_BUS_Q, bus_if.BUS_VALID, bus_if.LAST_SRC, bus_if.CONTENTION_STICKY); end
      $display("txn async_reset: q=%h valid=%b last=%0d", bus_if.DATA_BUS_Q, bus_if.BUS_VALID, bus_if.LAST_SRC);
   endtask

   initial begin
      RESET            = 1'b1;
      bus_if.SRC_DATA  = '0;
      bus_if.SRC_EN    = '0;
      bus_if.ALWAYS_ON = '0;
      bus_if.HOLD      = 1'b0;
      bus_if.CLEAR_ERR = 1'b0;
      test_reset();
      test_single_source();
      test_keeper();
      test_back_to_back();
      test_contention();
      test_clear_race();
      test_hold();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/data_bus_hub_n.md
# data_bus_hub_n

Parametrised successor to the CPU's data-bus hub. Merges `N_SRC` enable-gated sources plus one unconditional term onto a `WIDTH`-bit data bus, as before. Adds a registered bus copy with bus-keeper hold and last-driver tracking. Adds optional contention detection with sticky flag and saturating event counter. Sits between the control unit's bus-enable lines and every bus consumer: registers, RAM write port, debug/trace logic.

## Interface
Parameters:
- `WIDTH`, 16, bus width in bits.
- `N_SRC`, 8, number of gated sources (≥2).
- `CNT_WIDTH`, 8, width of contention counter.
- `SRC_IDX_W`, `$clog2(N_SRC)`, width of source index (derived, not overridden).

Ports:
- `CLK` in 1: system clock, rising edge.
- `RESET` in 1: asynchronous, active-high reset.
- `SRC_DATA` in `N_SRC*WIDTH`: source *i* occupies bits `[i*WIDTH +: WIDTH]`.
- `SRC_EN` in `N_SRC`: per-source bus enable, from control unit.
- `ALWAYS_ON` in `WIDTH`: unconditionally OR'd term (ALU result path); tie to 0 if unused.
- `HOLD` in 1: freeze registered outputs this cycle.
- `CLEAR_ERR` in 1: clear contention sticky flag and counter.
- `DATA_BUS` out `WIDTH`: combinational merged bus.
- `DATA_BUS_Q` out `WIDTH`: registered bus with keeper behaviour.
- `BUS_VALID` out 1: registered; `DATA_BUS_Q` was loaded on the last edge.
- `LAST_SRC` out `SRC_IDX_W`: index of the most recent sole driver.
- `CONTENTION` out 1: combinational; more than one `SRC_EN` is high.
- `CONTENTION_STICKY` out 1: registered sticky contention flag.
- `CONTENTION_COUNT` out `CNT_WIDTH`: saturating count of contention cycles.

## Operation
- `DATA_BUS` = OR over *i* of (`SRC_EN[i]` ? source *i* : 0), OR'd with `ALWAYS_ON`. This is purely combinational and zero-latency; legacy semantics are unchanged, and multiple enables OR together.
- Registered path, per rising edge, with `HOLD` taking priority:
  - `HOLD`=1: `DATA_BUS_Q`, `LAST_SRC` and `BUS_VALID` all hold.
  - Otherwise, if any `SRC_EN` is high: `DATA_BUS_Q` ← `DATA_BUS` and `BUS_VALID` ← 1.
  - Otherwise (no enable): `DATA_BUS_Q` holds (keeper) and `BUS_VALID` ← 0. `ALWAYS_ON` alone never loads `DATA_BUS_Q`.
- `LAST_SRC` updates only when exactly one `SRC_EN` is high and `HOLD`=0. Contention cycles leave it unchanged.
- Contention, when `CONTENTION` is high and `HOLD`=0:
  - sticky ← 1;
  - count ← count+1, saturating at all-ones.
- `HOLD` does not mask the combinational `CONTENTION` output, only its registered effects.
- `CLEAR_ERR` with no simultaneous contention: sticky ← 0 and count ← 0.
- `CLEAR_ERR` and contention in the same cycle: contention wins. Sticky ← 1 and count ← 1.
- Reset values:
  - `DATA_BUS_Q`=0;
  - `BUS_VALID`=0;
  - `LAST_SRC`=0;
  - `CONTENTION_STICKY`=0;
  - `CONTENTION_COUNT`=0.
- Reset asserted mid-operation clears all registers immediately, independent of `CLK`. Combinational outputs keep following their inputs during reset.

## Timing
- `DATA_BUS` and `CONTENTION` follow their inputs in the same cycle.
- `DATA_BUS_Q`, `BUS_VALID`, `LAST_SRC`, sticky and count all have exactly one cycle of latency from the sampled inputs.
- There is no handshake. The control unit guarantees enables are stable before the edge.
- `BUS_VALID` is a single-cycle indication per loaded edge. Back-to-back enabled cycles keep it high continuously.
- Counter saturation:
  - at 2^`CNT_WIDTH`−1, further contention keeps the value and sticky stays 1;
  - the counter never wraps.

## Configuration
- Macro `DATA_BUS_CONTENTION_CHECK_EN`.
- Defined: contention logic is present as described above.
- Undefined:
  - `CONTENTION`, `CONTENTION_STICKY` and `CONTENTION_COUNT` are tied to 0;
  - `CLEAR_ERR` is ignored;
  - no counter or sticky flops are synthesised.
- `LAST_SRC` behaviour is unchanged either way. Its "exactly one enable" qualification still applies, and is computed by the sub-module.

## Structure
- Shared package `data_bus_pkg`:
  - `DATA_BUS_WIDTH` = 16 default constant;
  - `DATA_BUS_N_SRC` = 8 default constant;
  - source-index constants (`SRC_DST`=0, `SRC_SRC`=1, `SRC_RAM`=2, `SRC_PC`=3, `SRC_OPERAND`=4, `SRC_KEYBOARD`=5, `SRC_SP`=6, spare 7);
  - a `bus_word_t` typedef.
- One sub-module, `bus_enable_decoder`. It takes `SRC_EN` and outputs:
  - `any_en`;
  - `one_hot` (exactly one set);
  - `multi_en`;
  - the encoded index of the lowest set bit.
- The top level holds the OR-merge, the registers and the counter.

## Test plan
- Single source: `SRC_EN`=8'b0000_0100, `RAM`=16'h1234, `ALWAYS_ON`=0.
  - `DATA_BUS`=16'h1234 in the same cycle.
  - Next edge: `DATA_BUS_Q`=16'h1234, `BUS_VALID`=1, `LAST_SRC`=2.
- Keeper: after the above, `SRC_EN`=0 and `ALWAYS_ON`=16'h00F0.
  - `DATA_BUS`=16'h00F0.
  - `DATA_BUS_Q` stays 16'h1234 and `BUS_VALID`=0.
- Contention: PC=16'h0F00 and SP=16'h00FF enabled together.
  - `DATA_BUS`=16'h0FFF and `CONTENTION`=1.
  - Next edge: sticky=1, count=1, `LAST_SRC` unchanged.
  - After 300 contention cycles with `CNT_WIDTH`=8, count=255.
- Clear race: `CLEAR_ERR`=1 in the same cycle as a contention.
  - Result: sticky=1, count=1.
  - Next cycle, `CLEAR_ERR` alone: both 0.
- Hold: `HOLD`=1 while `SRC_EN` selects OPERAND=16'hBEEF. `DATA_BUS_Q`, `BUS_VALID` and `LAST_SRC` are all unchanged.
- Async reset: assert `RESET` between edges mid-traffic. All registered outputs go to 0 without a clock edge. After deassert, the first enabled cycle loads normally.
  - Repeat with the macro undefined: contention outputs stay 0 throughout.
